// File: rtl/uart_rx_ovs_if.sv
// Output word handshake of the oversampling UART receiver.
// The receiver drives the master side and the consumer drives ready_i.
interface uart_rx_ovs_if;
    logic [8:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       break_o;
    logic       overrun_o;

    modport master (
        output data_o, valid_o, parity_err_o, frame_err_o, break_o, overrun_o,
        input  ready_i
    );

    modport slave (
        input  data_o, valid_o, parity_err_o, frame_err_o, break_o, overrun_o,
        output ready_i
    );
endinterface

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 3-sample majority per bit, 5..9 data bits,
// optional parity, 1 or 2 stop bits, break detection and an overrun flag.
module uart_rx_ovs #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic               rx_i,
    input  logic [DIV_W-1:0]   div_i,
    input  logic [3:0]         data_size_i,
    input  logic               parity_en_i,
    input  logic               parity_odd_i,
    input  logic               stop_size_i,
    uart_rx_ovs_if.master      bus
);

    localparam int unsigned SampW = $clog2(OVERSAMPLE);
    localparam logic [SampW-1:0] SampA    = SampW'(OVERSAMPLE / 2 - 1);
    localparam logic [SampW-1:0] SampB    = SampW'(OVERSAMPLE / 2);
    localparam logic [SampW-1:0] SampC    = SampW'(OVERSAMPLE / 2 + 1);
    localparam logic [SampW-1:0] SampLast = SampW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e            state_q;
    logic [DIV_W-1:0]  tick_cnt_q;
    logic [SampW-1:0]  samp_cnt_q;
    logic [3:0]        bit_cnt_q;
    logic              stop_cnt_q;
    logic              s0_q, s1_q;
    logic [8:0]        shreg_q;
    logic              par_bit_q;
    logic              stop_err_q;
    logic              stop1_q;
    logic [3:0]        size_q;
    logic              pe_q, odd_q, ss_q;
    logic              rx_meta_q, rxs_q, rxs_prev_q;

    logic       tick, samp_a, samp_b, decide, bit_end, maj, start_edge;
    logic       complete, first_stop, fe_new, brk_new, pe_new;
    logic [3:0] size_clamp;

    assign tick       = (state_q != StIdle) && (tick_cnt_q == div_i);
    assign samp_a     = tick && (samp_cnt_q == SampA);
    assign samp_b     = tick && (samp_cnt_q == SampB);
    assign decide     = tick && (samp_cnt_q == SampC);
    assign bit_end    = tick && (samp_cnt_q == SampLast);
    // Third sample is the live synchronised value at the decision tick.
    assign maj        = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
    assign start_edge = rxs_prev_q & ~rxs_q;

    assign size_clamp = (data_size_i < 4'd5) ? 4'd5 :
                        (data_size_i > 4'd9) ? 4'd9 : data_size_i;

    assign complete   = en_i && (state_q == StStop) && decide && (stop_cnt_q == ss_q);
    assign first_stop = (stop_cnt_q == 1'b0) ? maj : stop1_q;
    assign fe_new     = stop_err_q | ~maj;
    assign brk_new    = (shreg_q == 9'd0) && (!pe_q || !par_bit_q) && !first_stop;
    assign pe_new     = pe_q & (^shreg_q ^ par_bit_q ^ odd_q);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q          <= StIdle;
            tick_cnt_q       <= '0;
            samp_cnt_q       <= '0;
            bit_cnt_q        <= '0;
            stop_cnt_q       <= 1'b0;
            s0_q             <= 1'b0;
            s1_q             <= 1'b0;
            shreg_q          <= '0;
            par_bit_q        <= 1'b0;
            stop_err_q       <= 1'b0;
            stop1_q          <= 1'b0;
            size_q           <= 4'd5;
            pe_q             <= 1'b0;
            odd_q            <= 1'b0;
            ss_q             <= 1'b0;
            rx_meta_q        <= 1'b1;
            rxs_q            <= 1'b1;
            rxs_prev_q       <= 1'b1;
            bus.data_o       <= '0;
            bus.valid_o      <= 1'b0;
            bus.parity_err_o <= 1'b0;
            bus.frame_err_o  <= 1'b0;
            bus.break_o      <= 1'b0;
            bus.overrun_o    <= 1'b0;
        end else begin
            rx_meta_q  <= rx_i;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;

            if (state_q == StIdle || tick) begin
                tick_cnt_q <= '0;
            end else begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
            end
            if (tick) begin
                samp_cnt_q <= (samp_cnt_q == SampLast) ? '0 : samp_cnt_q + 1'b1;
            end
            if (samp_a) s0_q <= rxs_q;
            if (samp_b) s1_q <= rxs_q;

            if (!en_i) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start_edge) begin
                            state_q    <= StStart;
                            samp_cnt_q <= '0;
                            bit_cnt_q  <= '0;
                            stop_cnt_q <= 1'b0;
                            shreg_q    <= '0;
                            par_bit_q  <= 1'b0;
                            stop_err_q <= 1'b0;
                            size_q     <= size_clamp;
                            pe_q       <= parity_en_i;
                            odd_q      <= parity_odd_i;
                            ss_q       <= stop_size_i;
                        end
                    end
                    StStart: begin
                        if (decide && maj) begin
                            state_q <= StIdle;
                        end else if (bit_end) begin
                            state_q <= StData;
                        end
                    end
                    StData: begin
                        if (decide) shreg_q[bit_cnt_q] <= maj;
                        if (bit_end) begin
                            if (bit_cnt_q == size_q - 4'd1) begin
                                state_q <= pe_q ? StParity : StStop;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    StParity: begin
                        if (decide) par_bit_q <= maj;
                        if (bit_end) state_q <= StStop;
                    end
                    StStop: begin
                        if (decide) begin
                            if (!maj) stop_err_q <= 1'b1;
                            if (stop_cnt_q == 1'b0) stop1_q <= maj;
                            // Leave at mid-stop so a following start edge is not missed.
                            if (stop_cnt_q == ss_q) state_q <= StIdle;
                        end else if (bit_end) begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end

            if (complete && (!bus.valid_o || bus.ready_i)) begin
                bus.data_o       <= shreg_q;
                bus.parity_err_o <= pe_new;
                bus.frame_err_o  <= fe_new;
                bus.break_o      <= brk_new;
                bus.valid_o      <= 1'b1;
                if (bus.valid_o) bus.overrun_o <= 1'b0;
            end else if (complete) begin
                bus.overrun_o <= 1'b1;
            end else if (bus.valid_o && bus.ready_i) begin
                bus.valid_o   <= 1'b0;
                bus.overrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Self-checking bench for uart_rx_ovs: directed frames from the requirement list
// plus randomized frames checked against a frame-level reference model.
module tb_uart_rx_ovs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        rx;
    logic [15:0] div;
    logic [3:0]  data_size;
    logic        parity_en, parity_odd, stop_size;

    uart_rx_ovs_if bus ();

    uart_rx_ovs #(.OVERSAMPLE(16), .DIV_W(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .rx_i         (rx),
        .div_i        (div),
        .data_size_i  (data_size),
        .parity_en_i  (parity_en),
        .parity_odd_i (parity_odd),
        .stop_size_i  (stop_size),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int bitclk = 16;
    logic [11:0] wq[$];

    // Every accepted word, packed {break, frame_err, parity_err, data}.
    always @(negedge clk) begin
        if (rst_n && bus.valid_o && bus.ready_i)
            wq.push_back({bus.break_o, bus.frame_err_o, bus.parity_err_o, bus.data_o});
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic config_frame(input logic [3:0] sz, input bit pe, input bit odd, input bit ss);
        data_size  = sz;
        parity_en  = pe;
        parity_odd = odd;
        stop_size  = ss;
    endtask

    // Drives start, sz data bits LSB first, optional parity, stop bits, one idle bit.
    task automatic send_frame(input logic [8:0] d, input int sz, input bit pe, input bit par,
                              input bit ss, input bit st1, input bit st2);
        hold(1'b0, bitclk);
        for (int i = 0; i < sz; i++) hold(d[i], bitclk);
        if (pe) hold(par, bitclk);
        hold(st1, bitclk);
        if (ss) hold(st2, bitclk);
        hold(1'b1, bitclk);
    endtask

    function automatic int clamp_size(input int raw);
        return (raw < 5) ? 5 : (raw > 9) ? 9 : raw;
    endfunction

    function automatic logic [11:0] model(input logic [8:0] d, input int sz, input bit pe,
                                          input bit odd, input bit par, input bit ss,
                                          input bit st1, input bit st2);
        int         mask;
        logic [8:0] dm;
        int         ones;
        bit         perr, ferr, brk;
        mask = (1 << sz) - 1;
        dm   = d & mask[8:0];
        ones = 0;
        for (int i = 0; i < 9; i++) ones += int'(dm[i]);
        perr = pe && (((ones + int'(par) + int'(odd)) % 2) == 1);
        ferr = !st1 || (ss && !st2);
        brk  = (dm == 9'd0) && (!pe || !par) && !st1;
        return {brk, ferr, perr, dm};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.valid_o !== 1'b0) $display("FAIL reset_valid got=%b want=0", bus.valid_o);
        else passes++;
        checks++;
        if (bus.data_o !== 9'd0) $display("FAIL reset_data got=%h want=000", bus.data_o);
        else passes++;
        checks++;
        if ({bus.parity_err_o, bus.frame_err_o, bus.break_o, bus.overrun_o} !== 4'b0)
            $display("FAIL reset_flags got=%b%b%b%b want=0000", bus.parity_err_o,
                     bus.frame_err_o, bus.break_o, bus.overrun_o);
        else passes++;
        rst_n = 1'b1;
        hold(1'b1, 2 * bitclk);
    endtask

    task automatic test_directed;
        logic [11:0] w;
        wq.delete();
        config_frame(4'd8, 1'b0, 1'b0, 1'b0);
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (wq.size() !== 1) $display("FAIL a5_count got=%0d want=1", wq.size());
        else passes++;
        w = (wq.size() > 0) ? wq.pop_front() : 12'hfff;
        checks++;
        if (w !== 12'h0A5) $display("FAIL a5_word got=%h want=0a5", w);
        else passes++;

        config_frame(4'd7, 1'b1, 1'b0, 1'b0);
        send_frame(9'h055, 7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        w = (wq.size() > 0) ? wq.pop_front() : 12'hfff;
        checks++;
        if (w !== {3'b001, 9'h055}) $display("FAIL 7e1_word got=%h want=%h", w, {3'b001, 9'h055});
        else passes++;

        config_frame(4'd7, 1'b1, 1'b1, 1'b0);
        send_frame(9'h055, 7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        w = (wq.size() > 0) ? wq.pop_front() : 12'hfff;
        checks++;
        if (w !== 12'h055) $display("FAIL 7o1_word got=%h want=055", w);
        else passes++;

        config_frame(4'd9, 1'b0, 1'b0, 1'b1);
        send_frame(9'h1C3, 9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        w = (wq.size() > 0) ? wq.pop_front() : 12'hfff;
        checks++;
        if (w !== {3'b010, 9'h1C3}) $display("FAIL 9n2_word got=%h want=%h", w, {3'b010, 9'h1C3});
        else passes++;
    endtask

    task automatic test_random;
        int          divs[3] = '{0, 1, 2};
        logic [11:0] w, exp;
        int          raw, sz;
        logic [8:0]  d;
        bit          pe, odd, par, ss, st1, st2;
        for (int k = 0; k < 3; k++) begin
            div    = 16'(divs[k]);
            bitclk = 16 * (divs[k] + 1);
            hold(1'b1, bitclk);
            for (int n = 0; n < ((k == 0) ? 30 : 6); n++) begin
                raw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(5, 9);
                sz  = clamp_size(raw);
                d   = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom);
                pe  = 1'($urandom);
                odd = 1'($urandom);
                par = 1'($urandom);
                ss  = 1'($urandom);
                st1 = ($urandom_range(0, 4) != 0);
                st2 = ($urandom_range(0, 4) != 0);
                wq.delete();
                config_frame(4'(raw), pe, odd, ss);
                send_frame(d, sz, pe, par, ss, st1, st2);
                exp = model(d, sz, pe, odd, par, ss, st1, st2);
                checks++;
                if (wq.size() !== 1) $display("FAIL rand_count div=%0d n=%0d got=%0d want=1",
                                              divs[k], n, wq.size());
                else passes++;
                w = (wq.size() > 0) ? wq.pop_front() : 12'hfff;
                checks++;
                if (w !== exp) $display("FAIL rand_word div=%0d n=%0d got=%h want=%h",
                                        divs[k], n, w, exp);
                else passes++;
            end
        end
        div    = 16'd0;
        bitclk = 16;
        hold(1'b1, bitclk);
    endtask

    task automatic test_break;
        logic [11:0] w;
        wq.delete();
        config_frame(4'd8, 1'b0, 1'b0, 1'b0);
        hold(1'b0, 20 * bitclk);
        hold(1'b1, 2 * bitclk);
        checks++;
        if (wq.size() !== 1) $display("FAIL break_count got=%0d want=1", wq.size());
        else passes++;
        w = (wq.size() > 0) ? wq.pop_front() : 12'hfff;
        checks++;
        if (w !== {3'b110, 9'h000}) $display("FAIL break_word got=%h want=%h", w, {3'b110, 9'h000});
        else passes++;
        send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        w = (wq.size() > 0) ? wq.pop_front() : 12'hfff;
        checks++;
        if (w !== 12'h05A) $display("FAIL after_break got=%h want=05a", w);
        else passes++;
    endtask

    task automatic test_overrun;
        logic [11:0] w;
        wq.delete();
        config_frame(4'd8, 1'b0, 1'b0, 1'b0);
        bus.ready_i = 1'b0;
        send_frame(9'h011, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(9'h022, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.valid_o !== 1'b1) $display("FAIL ovr_valid got=%b want=1", bus.valid_o);
        else passes++;
        checks++;
        if (bus.data_o !== 9'h011) $display("FAIL ovr_data got=%h want=011", bus.data_o);
        else passes++;
        checks++;
        if (bus.overrun_o !== 1'b1) $display("FAIL ovr_flag got=%b want=1", bus.overrun_o);
        else passes++;
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.ready_i = 1'b0;
        checks++;
        if ({bus.valid_o, bus.overrun_o} !== 2'b00)
            $display("FAIL ovr_clear got=%b%b want=00", bus.valid_o, bus.overrun_o);
        else passes++;
        w = (wq.size() > 0) ? wq.pop_front() : 12'hfff;
        checks++;
        if (w !== 12'h011 || wq.size() != 0)
            $display("FAIL ovr_taken got=%h left=%0d want=011 left=0", w, wq.size());
        else passes++;
        bus.ready_i = 1'b1;
        hold(1'b1, bitclk);
    endtask

    task automatic test_glitch;
        wq.delete();
        hold(1'b0, 4);
        hold(1'b1, 3 * bitclk);
        checks++;
        if (wq.size() !== 0 || bus.valid_o !== 1'b0)
            $display("FAIL glitch got=%0d words valid=%b want=0 words", wq.size(), bus.valid_o);
        else passes++;
    endtask

    task automatic test_reset_mid;
        logic [11:0] w;
        logic [8:0]  d = 9'h096;
        wq.delete();
        config_frame(4'd8, 1'b0, 1'b0, 1'b0);
        hold(1'b0, bitclk);
        for (int i = 0; i < 4; i++) hold(d[i], bitclk);
        hold(d[4], bitclk / 2);
        rst_n = 1'b0;
        hold(1'b1, 3);
        rst_n = 1'b1;
        hold(1'b1, 2 * bitclk);
        checks++;
        if (wq.size() !== 0 || bus.valid_o !== 1'b0)
            $display("FAIL rst_mid_quiet got=%0d words want=0", wq.size());
        else passes++;
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        w = (wq.size() > 0) ? wq.pop_front() : 12'hfff;
        checks++;
        if (w !== 12'h03C) $display("FAIL rst_mid_next got=%h want=03c", w);
        else passes++;
    endtask

    task automatic test_enable;
        logic [11:0] w;
        wq.delete();
        config_frame(4'd8, 1'b0, 1'b0, 1'b0);
        hold(1'b0, bitclk);
        hold(1'b1, 3 * bitclk);
        en = 1'b0;
        @(posedge clk);
        #1;
        en = 1'b1;
        hold(1'b1, 8 * bitclk);
        checks++;
        if (wq.size() !== 0) $display("FAIL en_drop got=%0d words want=0", wq.size());
        else passes++;
        send_frame(9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        w = (wq.size() > 0) ? wq.pop_front() : 12'hfff;
        checks++;
        if (w !== 12'h0C3) $display("FAIL en_next got=%h want=0c3", w);
        else passes++;
    endtask

    initial begin
        rst_n       = 1'b0;
        en          = 1'b1;
        rx          = 1'b1;
        div         = 16'd0;
        bus.ready_i = 1'b1;
        config_frame(4'd8, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_directed();
        test_break();
        test_overrun();
        test_glitch();
        test_reset_mid();
        test_enable();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
